// File: rtl/note_sequencer_if.sv
// Control, step-memory write and playback status bundle between the
// register/control logic (master) and the note sequencer (slave).
interface note_sequencer_if #(
  parameter int TEMPO_W = 24
);
  logic               START;
  logic               STOP;
  logic               LOOP;
  logic [3:0]         LEN;
  logic [TEMPO_W-1:0] TICK_DIV;
  logic               WR_EN;
  logic [3:0]         WR_ADDR;
  logic [2:0]         WR_DATA;
  logic [1:0]         NOTE_SEL;
  logic               GATE;
  logic [3:0]         STEP;
  logic               BUSY;
  logic               DONE;

  modport master (
    output START, STOP, LOOP, LEN, TICK_DIV, WR_EN, WR_ADDR, WR_DATA,
    input  NOTE_SEL, GATE, STEP, BUSY, DONE
  );

  modport slave (
    input  START, STOP, LOOP, LEN, TICK_DIV, WR_EN, WR_ADDR, WR_DATA,
    output NOTE_SEL, GATE, STEP, BUSY, DONE
  );
endinterface

// File: rtl/note_sequencer.sv
// Step sequencer: plays up to 16 entries of an internal step memory at a
// programmable tempo, driving the oscillator note select and a gate.
module note_sequencer #(
  parameter int TEMPO_W = 24,
  parameter int GAP_CYC = 16
) (
  input logic             CLK,
  input logic             RST_N,
  note_sequencer_if.slave bus
);
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam logic [TEMPO_W:0] GAP_EXT = (TEMPO_W+1)'(GAP_CYC);

  state_t             state_r, state_s;
  logic [TEMPO_W-1:0] cnt_r, cnt_s;
  logic [TEMPO_W-1:0] tick_r, tick_s;
  logic [3:0]         step_r, step_s;
  logic [1:0]         note_r, note_s;
  logic               gate_r, gate_s;
  logic               done_r, done_s;
  logic [2:0]         mem_r [16];
  logic [3:0]         next_idx_s;
  logic [2:0]         next_entry_s;
  logic               boundary_s;
  logic               gap_hit_s;

  // Step to load next: step+1 while below LEN, otherwise step 0 (start or wrap)
  assign next_idx_s   = ((state_r == PLAY) && (step_r < bus.LEN)) ? step_r + 4'd1 : 4'd0;
  assign next_entry_s = mem_r[next_idx_s];
  assign boundary_s   = (cnt_r == tick_r);
  // Gate drops one cycle ahead so the registered GATE is low from cnt == TICK_DIV+1-GAP_CYC
  assign gap_hit_s    = ({1'b0, tick_r} >= GAP_EXT) &&
                        ({1'b0, cnt_r} == ({1'b0, tick_r} - GAP_EXT));

  // Next-state and next-output logic for the IDLE/PLAY controller
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    tick_s  = tick_r;
    step_s  = step_r;
    note_s  = note_r;
    gate_s  = gate_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.STOP) begin
          cnt_s  = '0;
          gate_s = 1'b0;
        end else if (bus.START) begin
          state_s = PLAY;
          tick_s  = bus.TICK_DIV;
          cnt_s   = '0;
          step_s  = next_idx_s;
          note_s  = next_entry_s[1:0];
          gate_s  = ~next_entry_s[2];
        end else begin
          cnt_s = '0;
        end
      end
      PLAY: begin
        if (bus.STOP) begin
          state_s = IDLE;
          cnt_s   = '0;
          gate_s  = 1'b0;
        end else if (boundary_s) begin
          cnt_s  = '0;
          tick_s = bus.TICK_DIV;
          if ((step_r < bus.LEN) || bus.LOOP) begin
            step_s = next_idx_s;
            note_s = next_entry_s[1:0];
            gate_s = ~next_entry_s[2];
          end else begin
            state_s = IDLE;
            done_s  = 1'b1;
            gate_s  = 1'b0;
          end
        end else begin
          cnt_s = cnt_r + TEMPO_W'(1);
          if (gap_hit_s) begin
            gate_s = 1'b0;
          end else begin
            gate_s = gate_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        gate_s  = 1'b0;
      end
    endcase
  end

  // Controller state, step counter and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      tick_r  <= '0;
      step_r  <= 4'd0;
      note_r  <= 2'd0;
      gate_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      tick_r  <= tick_s;
      step_r  <= step_s;
      note_r  <= note_s;
      gate_r  <= gate_s;
      done_r  <= done_s;
    end
  end

  // Step memory; a load in the same cycle as a write sees the old entry
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) begin
        mem_r[i] <= 3'b000;
      end
    end else if (bus.WR_EN) begin
      mem_r[bus.WR_ADDR] <= bus.WR_DATA;
    end else begin
      mem_r[bus.WR_ADDR] <= mem_r[bus.WR_ADDR];
    end
  end

  assign bus.NOTE_SEL = note_r;
  assign bus.GATE     = gate_r;
  assign bus.STEP     = step_r;
  assign bus.BUSY     = (state_r == PLAY);
  assign bus.DONE     = done_r;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: table of patterns checked cycle by
// cycle through an expected-output queue, plus hand-written corner sequences.
module tb_note_sequencer;
  localparam int TW  = 24;
  localparam int GAP = 16;

  logic CLK = 1'b0;
  logic RST_N;
  always #10 CLK = ~CLK;

  note_sequencer_if #(.TEMPO_W(TW)) bus ();
  note_sequencer #(.TEMPO_W(TW), .GAP_CYC(GAP)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  typedef struct {
    logic [11:0]   mem4;     // entries 0..3, entry 0 in bits 2:0
    logic [3:0]    len;
    logic [TW-1:0] tick;
    logic          loop_en;
    int            passes;
    int            exp_busy;
  } vec_t;

  vec_t       vecs [6];
  logic [2:0] mem_model [16];
  logic [8:0] exp_q [$];     // {busy, done, gate, step[3:0], note[1:0]}
  logic [8:0] pop_e;
  logic [5:0] hexp [6];
  int checks = 0, passed = 0, busy_cnt = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step_clk();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [2:0] d);
    bus.WR_EN = 1'b1; bus.WR_ADDR = a; bus.WR_DATA = d;
    step_clk();
    bus.WR_EN = 1'b0;
    mem_model[a] = d;
  endtask

  // Expected per-cycle outputs of a whole playback, from the step contents
  task automatic push_trace(input logic [3:0] len, input int tick, input int passes);
    logic [2:0] e;
    logic       g;
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s <= int'(len); s++) begin
        e = mem_model[4'(s)];
        for (int c = 0; c <= tick; c++) begin
          g = !e[2] && ((tick < GAP) || (c < tick + 1 - GAP));
          exp_q.push_back({1'b1, 1'b0, g, 4'(s), e[1:0]});
        end
      end
    end
    e = mem_model[len];
    exp_q.push_back({1'b0, 1'b1, 1'b0, len, e[1:0]});
    exp_q.push_back({1'b0, 1'b0, 1'b0, len, e[1:0]});
  endtask

  task automatic play(input logic [3:0] len, input logic [TW-1:0] tick, input logic loop_en,
                      input int passes, input int exp_busy);
    int guard;
    bus.LEN = len; bus.TICK_DIV = tick; bus.LOOP = loop_en; bus.START = 1'b1;
    step_clk();
    bus.START = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    push_trace(len, int'(tick), passes);
    if (passes > 1) begin
      repeat ((passes - 1) * (int'(len) + 1) * (int'(tick) + 1) +
              ((len > 4'd0) ? int'(len) - 1 : 0) * (int'(tick) + 1) + 1) step_clk();
      bus.LOOP = 1'b0;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 20000) begin
      step_clk();
      guard++;
    end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    chk("busy_len", busy_cnt, exp_busy);
    chk("done_cnt", done_cnt, 1);
  endtask

  // Output sampler on the inactive edge
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (bus.BUSY) busy_cnt++;
      if (bus.DONE) done_cnt++;
      if (exp_q.size() > 0) begin
        pop_e = exp_q.pop_front();
        chk("trace", {23'd0, bus.BUSY, bus.DONE, bus.GATE, bus.STEP, bus.NOTE_SEL}, {23'd0, pop_e});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mem4: {3'd3, 3'd2, 3'd1, 3'd0}, len: 4'd3, tick: 24'd99, loop_en: 1'b0, passes: 1, exp_busy: 400};
    vecs[1] = '{mem4: {3'd3, 3'd2, 3'd1, 3'd0}, len: 4'd3, tick: 24'd99, loop_en: 1'b1, passes: 2, exp_busy: 800};
    vecs[2] = '{mem4: {3'b001, 3'b011, 3'b100, 3'b010}, len: 4'd3, tick: 24'd3, loop_en: 1'b0, passes: 1, exp_busy: 16};
    vecs[3] = '{mem4: {3'b000, 3'b011, 3'b010, 3'b001}, len: 4'd2, tick: 24'd0, loop_en: 1'b0, passes: 1, exp_busy: 3};
    vecs[4] = '{mem4: {3'b000, 3'b000, 3'b110, 3'b011}, len: 4'd1, tick: 24'd16, loop_en: 1'b0, passes: 1, exp_busy: 34};
    vecs[5] = '{mem4: {3'b000, 3'b000, 3'b000, 3'b010}, len: 4'd0, tick: 24'd15, loop_en: 1'b0, passes: 1, exp_busy: 16};
    // {busy, done, step} per cycle for LEN=1, TICK_DIV=1 with START held high
    hexp[0] = 6'b100000; hexp[1] = 6'b100000; hexp[2] = 6'b100001;
    hexp[3] = 6'b100001; hexp[4] = 6'b010001; hexp[5] = 6'b100000;

    for (int i = 0; i < 16; i++) mem_model[i] = 3'b000;
    RST_N = 1'b0;
    bus.START = 1'b0; bus.STOP = 1'b0; bus.LOOP = 1'b0; bus.LEN = 4'd0;
    bus.TICK_DIV = '0; bus.WR_EN = 1'b0; bus.WR_ADDR = 4'd0; bus.WR_DATA = 3'd0;
    #35;
    chk("reset_out", {23'd0, bus.BUSY, bus.DONE, bus.GATE, bus.STEP, bus.NOTE_SEL}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    step_clk();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) wr(4'(i), vecs[v].mem4[3*i +: 3]);
      play(vecs[v].len, vecs[v].tick, vecs[v].loop_en, vecs[v].passes, vecs[v].exp_busy);
    end

    // START held through playback: ignored in PLAY, re-enters after one IDLE cycle
    bus.LEN = 4'd1; bus.TICK_DIV = 24'd1; bus.LOOP = 1'b0; bus.START = 1'b1;
    step_clk();
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("start_held", {26'd0, bus.BUSY, bus.DONE, bus.STEP}, {26'd0, hexp[i]});
    end
    @(posedge CLK); #1;
    bus.STOP = 1'b1; bus.START = 1'b0;
    step_clk();
    bus.STOP = 1'b0;
    chk("stop_idle", {31'd0, bus.BUSY}, 32'd0);
    step_clk();

    // STOP coincident with the step-2 boundary
    bus.LEN = 4'd3; bus.TICK_DIV = 24'd9; bus.START = 1'b1;
    step_clk();
    bus.START = 1'b0;
    repeat (29) step_clk();
    chk("pre_stop_step", {28'd0, bus.STEP}, 32'd2);
    bus.STOP = 1'b1;
    step_clk();
    chk("stop_bnd", {29'd0, bus.BUSY, bus.GATE, bus.DONE}, 32'd0);
    chk("stop_step_hold", {28'd0, bus.STEP}, 32'd2);
    bus.START = 1'b1;
    step_clk();
    step_clk();
    chk("start_stop_idle", {31'd0, bus.BUSY}, 32'd0);
    bus.STOP = 1'b0; bus.START = 1'b0;
    step_clk();
    chk("no_done_after_stop", {30'd0, bus.BUSY, bus.DONE}, 32'd0);

    // Write to step 1 in its own load cycle
    for (int i = 0; i < 4; i++) wr(4'(i), 3'(i));
    bus.LEN = 4'd3; bus.TICK_DIV = 24'd4; bus.LOOP = 1'b1; bus.START = 1'b1;
    step_clk();
    bus.START = 1'b0;
    repeat (4) step_clk();
    bus.WR_EN = 1'b1; bus.WR_ADDR = 4'd1; bus.WR_DATA = 3'b010;
    step_clk();
    bus.WR_EN = 1'b0;
    mem_model[1] = 3'b010;
    chk("coll_old", {26'd0, bus.STEP, bus.NOTE_SEL}, {26'd0, 4'd1, 2'd1});
    repeat (20) step_clk();
    chk("coll_new", {26'd0, bus.STEP, bus.NOTE_SEL}, {26'd0, 4'd1, 2'd2});
    bus.STOP = 1'b1; bus.LOOP = 1'b0;
    step_clk();
    bus.STOP = 1'b0;
    chk("coll_stop", {31'd0, bus.BUSY}, 32'd0);

    // Asynchronous reset mid-playback clears outputs and memory
    for (int i = 0; i < 4; i++) wr(4'(i), 3'b011);
    bus.LEN = 4'd3; bus.TICK_DIV = 24'd9; bus.LOOP = 1'b1; bus.START = 1'b1;
    step_clk();
    bus.START = 1'b0;
    repeat (15) step_clk();
    chk("pre_rst", {27'd0, bus.BUSY, bus.STEP}, {27'd0, 1'b1, 4'd1});
    #3 RST_N = 1'b0;
    #2;
    chk("rst_async", {23'd0, bus.BUSY, bus.DONE, bus.GATE, bus.STEP, bus.NOTE_SEL}, 32'd0);
    step_clk();
    #5 RST_N = 1'b1;
    for (int i = 0; i < 16; i++) mem_model[i] = 3'b000;
    bus.LOOP = 1'b0;
    step_clk();
    play(4'd3, 24'd3, 1'b0, 1, 16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Step sequencer that drives the square-wave oscillator's note select and a gate signal. It plays a programmable pattern of up to 16 steps from an internal step memory at a programmable tempo, once or looped. It sits between the register/control logic and the oscillator: its NOTE_SEL feeds the oscillator directly, and GATE masks the oscillator's AUDIO downstream.

## Interface
- TEMPO_W, 24: width of TICK_DIV; the step-length counter is also this width.
- GAP_CYC, 16: number of cycles at the end of each step during which GATE is forced low.
- CLK  in  1  system clock, 50 MHz.
- RST_N  in  1  reset: RST_N, asynchronous, active-low; clock CLK.
- START  in  1  level-sampled start request; acted on only in IDLE.
- STOP  in  1  abort playback; highest priority.
- LOOP  in  1  sampled at the last step; 1 = wrap to step 0, 0 = finish.
- LEN  in  4  index of the last step (pattern length − 1); sampled at every step boundary.
- TICK_DIV  in  TEMPO_W  step length in cycles minus 1; sampled at START and at every step boundary.
- WR_EN  in  1  step-memory write strobe.
- WR_ADDR  in  4  step-memory write address.
- WR_DATA  in  3  step entry: bit2 = rest, bits1:0 = note index.
- NOTE_SEL  out  2  note index for the oscillator (registered).
- GATE  out  1  1 = current step sounding (registered).
- STEP  out  4  index of the step currently playing (registered).
- BUSY  out  1  1 while in PLAY.
- DONE  out  1  one-cycle pulse when a non-looped pattern completes.

## Operation
- Step memory is 16 × 3 bits. Reset clears every entry to 3'b000 (note 0, not a rest). Writes are accepted in any state, 1 cycle per write, and take effect at the end of the write cycle.
- Two states: IDLE and PLAY.
- IDLE → PLAY: START=1 and STOP=0. Latch TICK_DIV, clear the step counter (cnt) to 0, load step 0.
- Loading step k means setting STEP=k, NOTE_SEL=mem[k][1:0], and GATE=!mem[k][2]. The load reads memory before any same-cycle write, so a write to k in the load cycle is seen only on the next visit to k.
- In PLAY, cnt increments each cycle.
- The step boundary is at cnt == latched TICK_DIV. At the boundary, cnt is set to 0 and TICK_DIV is re-latched.
  - If STEP < LEN: load step STEP+1.
  - If STEP ≥ LEN and LOOP=1: load step 0.
  - If STEP ≥ LEN and LOOP=0: go to IDLE, pulse DONE, set GATE=0. NOTE_SEL and STEP hold their values.
- Articulation gap:
  - If latched TICK_DIV ≥ GAP_CYC, GATE goes low when cnt reaches TICK_DIV+1−GAP_CYC and stays low to the boundary.
  - If latched TICK_DIV < GAP_CYC, there is no gap.
  - Rest steps keep GATE low for the whole step.
- STOP=1 in any state: next cycle IDLE, GATE=0, BUSY=0, no DONE pulse, cnt=0. STOP wins over START and over a simultaneous boundary.
- START while in PLAY is ignored; playback does not restart.
- NOTE_SEL changes only at step loads. The oscillator itself retimes the note to its next output toggle, so the sequencer adds no glitch suppression.
- If LEN is lowered below the current STEP mid-pattern, the next boundary takes the "STEP ≥ LEN" path.

## Timing
- Reset values: NOTE_SEL=0, GATE=0, STEP=0, BUSY=0, DONE=0, state IDLE, cnt=0, memory all 0.
- START is sampled at edge N. From edge N, BUSY=1, STEP=0, NOTE_SEL and GATE show step 0.
- Each step lasts exactly TICK_DIV+1 cycles. TICK_DIV=0 gives 1-cycle steps (no gap unless GAP_CYC=0).
- A non-looped pattern of LEN+1 steps gives BUSY high for exactly (LEN+1)·(TICK_DIV+1) cycles.
- DONE is asserted in the first cycle after the final step, coincident with BUSY falling.
- After DONE, a START held high re-enters PLAY on the following edge, so there is 1 IDLE cycle between patterns.
- An asynchronous reset mid-playback returns all outputs to their reset values immediately. It also clears memory.

## Test plan
- Reset: with RST_N asserted mid-PLAY, all outputs are 0 within the reset interval and memory reads back as 0 on the next play.
- Program mem = {0,1,2,3}, LEN=3, TICK_DIV=99, GAP_CYC=16, LOOP=0, pulse START:
  - NOTE_SEL steps 0,1,2,3 at 100-cycle intervals.
  - GATE is high for 84 cycles and low for 16 cycles in each step.
  - DONE pulses once at cycle 400 and BUSY is high for exactly 400 cycles.
- Same pattern with LOOP=1: STEP wraps 3→0 with no idle cycle and DONE never pulses. Dropping LOOP during step 2 ends playback after step 3.
- Rest and short steps: mem[1]=3'b100, TICK_DIV=3 (< GAP_CYC):
  - GATE is low for all 4 cycles of step 1.
  - GATE is high for all 4 cycles of steps 0, 2 and 3.
- STOP during step 2, simultaneous with the boundary: next cycle BUSY=0, GATE=0, DONE=0. START and STOP together in IDLE keep the block in IDLE.
- Write collision: write mem[1]=2 in the load cycle of step 1 with old value 1:
  - NOTE_SEL=1 on this pass.
  - NOTE_SEL=2 on the next loop pass.
